// File: rtl/ifetch.sv
// Instruction fetch stage: one outstanding memory request, static next-PC
// prediction, and a small instruction queue feeding decode.
module ifetch #(
    parameter int unsigned IQ_DEPTH = 4,
    parameter logic [31:0] RESET_PC = 32'h0
) (
    input  logic        clk_in,
    input  logic        rst_in,
    input  logic        rdy_in,
    output logic        mem_req,
    output logic [31:0] mem_addr,
    input  logic        mem_done,
    input  logic [31:0] mem_ins,
    output logic        decode_flag,
    output logic [31:0] ins,
    output logic [31:0] ins_pc,
    output logic [31:0] ins_pred_pc,
    input  logic        decode_ok,
    input  logic        rob_clear,
    input  logic [31:0] rob_target_pc
);

    localparam int unsigned PTR_W = (IQ_DEPTH > 1) ? $clog2(IQ_DEPTH) : 1;
    localparam int unsigned CNT_W = PTR_W + 1;

    localparam logic [1:0] S_IDLE = 2'd0;
    localparam logic [1:0] S_WAIT = 2'd1;
    localparam logic [1:0] S_DROP = 2'd2;

    logic [1:0]       state_q, state_d;
    logic [31:0]      fetch_pc_q, fetch_pc_d;
    logic             mem_req_q, mem_req_d;
    logic [31:0]      mem_addr_q, mem_addr_d;
    logic [PTR_W-1:0] head_q, head_d;
    logic [PTR_W-1:0] tail_q, tail_d;
    logic [CNT_W-1:0] count_q, count_d;
    logic [31:0]      iq_ins_q  [IQ_DEPTH];
    logic [31:0]      iq_pc_q   [IQ_DEPTH];
    logic [31:0]      iq_pred_q [IQ_DEPTH];

    logic             push;
    logic             pop;
    logic [31:0]      pred_c;
    logic [31:0]      imm_jal;
    logic [31:0]      imm_br;

    // Static prediction: JAL and backward branches taken, everything else falls through
    always_comb begin
        imm_jal = {{11{mem_ins[31]}}, mem_ins[31], mem_ins[19:12], mem_ins[20],
                   mem_ins[30:21], 1'b0};
        imm_br  = {{19{mem_ins[31]}}, mem_ins[31], mem_ins[7], mem_ins[30:25],
                   mem_ins[11:8], 1'b0};
        pred_c  = fetch_pc_q + 32'd4;
        if (mem_ins[6:0] == 7'b1101111) begin
            pred_c = fetch_pc_q + imm_jal;
        end else if (mem_ins[6:0] == 7'b1100011 && mem_ins[31]) begin
            pred_c = fetch_pc_q + imm_br;
        end
    end

    assign decode_flag = (count_q != '0) && !rob_clear;
    assign ins         = iq_ins_q[head_q];
    assign ins_pc      = iq_pc_q[head_q];
    assign ins_pred_pc = iq_pred_q[head_q];
    assign mem_req     = mem_req_q;
    assign mem_addr    = mem_addr_q;

    // Next-state: fetch FSM plus queue pointer bookkeeping
    always_comb begin
        state_d    = state_q;
        fetch_pc_d = fetch_pc_q;
        mem_req_d  = mem_req_q;
        mem_addr_d = mem_addr_q;
        head_d     = head_q;
        tail_d     = tail_q;
        count_d    = count_q;
        push       = 1'b0;
        pop        = decode_flag && decode_ok;

        case (state_q)
            S_IDLE: begin
                if (!rob_clear && count_q < CNT_W'(IQ_DEPTH)) begin
                    state_d    = S_WAIT;
                    mem_req_d  = 1'b1;
                    mem_addr_d = fetch_pc_q;
                end
            end
            S_WAIT: begin
                if (mem_done) begin
                    state_d   = S_IDLE;
                    mem_req_d = 1'b0;
                    if (!rob_clear) begin
                        push       = 1'b1;
                        fetch_pc_d = pred_c;
                    end
                end else if (rob_clear) begin
                    state_d = S_DROP;
                end
            end
            S_DROP: begin
                if (mem_done) begin
                    state_d   = S_IDLE;
                    mem_req_d = 1'b0;
                end
            end
            default: begin
                state_d   = S_IDLE;
                mem_req_d = 1'b0;
            end
        endcase

        if (rob_clear) begin
            head_d     = '0;
            tail_d     = '0;
            count_d    = '0;
            fetch_pc_d = rob_target_pc;
        end else begin
            if (push) tail_d = tail_q + PTR_W'(1);
            if (pop)  head_d = head_q + PTR_W'(1);
            count_d = count_q + CNT_W'(push) - CNT_W'(pop);
        end
    end

    always_ff @(posedge clk_in) begin
        if (rst_in) begin
            state_q    <= S_IDLE;
            fetch_pc_q <= RESET_PC;
            mem_req_q  <= 1'b0;
            mem_addr_q <= '0;
            head_q     <= '0;
            tail_q     <= '0;
            count_q    <= '0;
            for (int i = 0; i < int'(IQ_DEPTH); i++) begin
                iq_ins_q[i]  <= '0;
                iq_pc_q[i]   <= '0;
                iq_pred_q[i] <= '0;
            end
        end else if (rdy_in) begin
            state_q    <= state_d;
            fetch_pc_q <= fetch_pc_d;
            mem_req_q  <= mem_req_d;
            mem_addr_q <= mem_addr_d;
            head_q     <= head_d;
            tail_q     <= tail_d;
            count_q    <= count_d;
            if (push) begin
                iq_ins_q[tail_q]  <= mem_ins;
                iq_pc_q[tail_q]   <= fetch_pc_q;
                iq_pred_q[tail_q] <= pred_c;
            end
        end
    end

endmodule
